cfs_md_arbiter: RTL and testbench
=================================

# cfs_md_arbiter

Round-robin arbiter that shares one downstream MD slave port between NUM_MASTERS upstream MD masters. It selects one requesting master and holds the grant for the whole transfer. While granted, it routes that master's data/offset/size to the slave and returns ready/err only to that master. It sits between multiple MD traffic sources and the single MD input of the aligner datapath, and keeps every MD protocol rule intact on both sides.

## Interface
- NUM_MASTERS, 2, number of upstream MD masters (legal range 2..8).
- DATA_WIDTH, 32, MD data width in bits (power of 2, at least 8).
- OFFSET_WIDTH, derived: max(1, clog2(DATA_WIDTH/8)).
- SIZE_WIDTH, derived: clog2(DATA_WIDTH/8)+1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- m_valid  in  NUM_MASTERS  per-master valid.
- m_data  in  NUM_MASTERS*DATA_WIDTH  per-master data; master i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- m_offset  in  NUM_MASTERS*OFFSET_WIDTH  per-master offset, same packing.
- m_size  in  NUM_MASTERS*SIZE_WIDTH  per-master size, same packing.
- m_ready  out  NUM_MASTERS  per-master ready.
- m_err  out  NUM_MASTERS  per-master err.
- s_valid  out  1  slave valid.
- s_data  out  DATA_WIDTH  slave data.
- s_offset  out  OFFSET_WIDTH  slave offset.
- s_size  out  SIZE_WIDTH  slave size.
- s_ready  in  1  slave ready.
- s_err  in  1  slave err.
- grant  out  NUM_MASTERS  registered one-hot grant; all zero when idle.
- busy  out  1  high in BUSY state.

## Operation
- Two states: IDLE and BUSY. Registers: state, grant, priority pointer ptr (clog2(NUM_MASTERS) bits).
- IDLE:
  - If any m_valid is high, choose the first valid master scanning ptr, ptr+1, ... with wrap modulo NUM_MASTERS.
  - Register its one-hot grant and move to BUSY.
  - If no master is valid, stay in IDLE with grant=0.
- BUSY, with g the granted index:
  - s_valid = m_valid[g]; s_data, s_offset, s_size = slices of master g.
  - m_ready[g] = s_ready; m_err[g] = s_err & s_ready.
  - For every other master, m_ready and m_err are 0.
- Completion: at a clock edge with state BUSY, m_valid[g]=1 and s_ready=1:
  - go to IDLE, clear grant, set ptr = (g+1) mod NUM_MASTERS.
- Abort: at an edge in BUSY with m_valid[g]=0 (protocol violation by the master):
  - go to IDLE, clear grant, set ptr = (g+1) mod NUM_MASTERS; no transfer is counted.
- Outside BUSY: s_valid=0; s_data, s_offset, s_size = 0; all m_ready and m_err = 0.
- The arbiter never modifies payload. Size/offset legality and payload stability are the master's responsibility and pass through unchanged.
- The grant never changes while s_valid=1 and s_ready=0, so slave-side valid/payload stay stable until ready.

## Timing
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE, grant=0, ptr=0, busy=0.
  - All combinational outputs are therefore 0: s_valid, s_data, s_offset, s_size, m_ready, m_err.
- Arbitration latency: m_valid rises in cycle T (state IDLE) → grant and busy high in cycle T+1 → s_valid high in cycle T+1.
- Earliest m_ready to the master is cycle T+1, if s_ready=1 in that cycle.
- After a completion edge, state is IDLE for one cycle (one bubble). Maximum throughput is one transfer per 2 cycles.
- Back-pressure: s_ready low for K cycles → grant is held, s_valid stays high, and the transfer completes K cycles later.
- Simultaneous requests in IDLE are resolved purely by ptr. The lowest index wins after reset.
- A master that raises valid while another master is granted waits. Its m_ready stays 0 until it is granted.
- ptr wraps from NUM_MASTERS-1 to 0.

## Test plan
- Single request: master1 drives data=0xA5A5_0001, offset=1, size=2 with s_ready tied 1 → grant=2'b10 one cycle later; s_* carries exactly that payload; m_ready[1] pulses for one cycle; returns to IDLE the next cycle.
- Contention, NUM_MASTERS=3: all masters valid continuously from reset → grant order 0,1,2,0,1 with an IDLE bubble between each.
- Back-pressure: s_ready held 0 for 4 cycles while master0 is granted and master1 is requesting → grant, s_valid and payload are stable; m_ready=0 for both masters; master1 is granted only after master0 completes.
- Error routing: s_err=1 together with s_ready=1 during master1's transfer → m_err=2'b10 for one cycle; m_err[0]=0 throughout.
- Reset mid-transfer: assert reset_n=0 while BUSY with s_ready=0 → grant, busy and s_valid drop immediately (asynchronously); after release, master0 wins when both masters request.
- Abort: the granted master drops m_valid before s_ready → the next state is IDLE and ptr advances past that master.

Source files
------------

// File: rtl/cfs_md_arbiter.sv
// -----------------------------------------------------------------------------
// cfs_md_arbiter
//
// Round-robin arbiter that shares one downstream MD slave port between
// NUM_MASTERS upstream MD masters. A requesting master is picked in IDLE.
// Its grant is held for the whole transfer, which ends on the valid/ready
// handshake. It also ends early if the granted master drops valid (abort).
// The arbiter then returns to IDLE for exactly one cycle before it
// arbitrates again.
//
// Ports:
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   m_valid   in   [NUM_MASTERS]               per-master valid
//   m_data    in   [NUM_MASTERS*DATA_WIDTH]    per-master data, master i at
//                                              [i*DATA_WIDTH +: DATA_WIDTH]
//   m_offset  in   [NUM_MASTERS*OFFSET_WIDTH]  per-master offset, same packing
//   m_size    in   [NUM_MASTERS*SIZE_WIDTH]    per-master size, same packing
//   m_ready   out  [NUM_MASTERS]               per-master ready (granted only)
//   m_err     out  [NUM_MASTERS]               per-master err (granted only)
//   s_valid   out  slave valid
//   s_data    out  [DATA_WIDTH]   slave data
//   s_offset  out  [OFFSET_WIDTH] slave offset
//   s_size    out  [SIZE_WIDTH]   slave size
//   s_ready   in   slave ready
//   s_err     in   slave err
//   grant     out  [NUM_MASTERS]  registered one-hot grant, zero when idle
//   busy      out  high while a transfer is granted
// -----------------------------------------------------------------------------
module cfs_md_arbiter #(
   parameter int NUM_MASTERS  = 2,
   parameter int DATA_WIDTH   = 32,
   localparam int BYTES        = DATA_WIDTH / 8,
   localparam int OFFSET_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1,
   localparam int SIZE_WIDTH   = $clog2(BYTES) + 1
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_MASTERS-1:0]              m_valid,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_data,
   input  logic [NUM_MASTERS*OFFSET_WIDTH-1:0] m_offset,
   input  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   m_size,
   output logic [NUM_MASTERS-1:0]              m_ready,
   output logic [NUM_MASTERS-1:0]              m_err,
   output logic                                s_valid,
   output logic [DATA_WIDTH-1:0]               s_data,
   output logic [OFFSET_WIDTH-1:0]             s_offset,
   output logic [SIZE_WIDTH-1:0]               s_size,
   input  logic                                s_ready,
   input  logic                                s_err,
   output logic [NUM_MASTERS-1:0]              grant,
   output logic                                busy
);

   localparam int PTR_W = $clog2(NUM_MASTERS);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]       ptr_q, ptr_d;

   logic                   busy_w;
   logic [PTR_W-1:0]       g_idx;      // index of the granted master
   logic [PTR_W-1:0]       g_idx_inc;  // (g_idx + 1) mod NUM_MASTERS
   logic                   win_found;
   logic [PTR_W-1:0]       win_idx;
   logic [PTR_W:0]         idx_sum;    // one extra bit so ptr+k cannot overflow

   assign busy_w = (state_q == BUSY);

   // One-hot to index. grant_q is zero in IDLE, so g_idx is 0 there. Every
   // use of g_idx is qualified by busy_w.
   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            g_idx = PTR_W'(i);
         end
      end
   end

   assign g_idx_inc = (g_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : g_idx + 1'b1;

   // Round-robin search starting at ptr_q. The index wraps modulo
   // NUM_MASTERS, which need not be a power of two.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx_sum   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx_sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
         if (idx_sum >= (PTR_W + 1)'(NUM_MASTERS)) begin
            idx_sum = idx_sum - (PTR_W + 1)'(NUM_MASTERS);
         end
         if (!win_found && m_valid[idx_sum[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = idx_sum[PTR_W-1:0];
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_found) begin
               grant_d[win_idx] = 1'b1;
               state_d          = BUSY;
            end
         end
         BUSY: begin
            // Completion (valid & ready) and abort (valid dropped) both
            // release the grant and move the pointer past this master.
            if (!m_valid[g_idx] || s_ready) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = g_idx_inc;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Slave side. The payload is forced to zero outside BUSY.
   always_comb begin
      s_valid  = 1'b0;
      s_data   = '0;
      s_offset = '0;
      s_size   = '0;
      if (busy_w) begin
         s_valid  = m_valid[g_idx];
         s_data   = m_data[g_idx*DATA_WIDTH +: DATA_WIDTH];
         s_offset = m_offset[g_idx*OFFSET_WIDTH +: OFFSET_WIDTH];
         s_size   = m_size[g_idx*SIZE_WIDTH +: SIZE_WIDTH];
      end
   end

   // Master side. Only the granted master sees ready/err.
   generate
      for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master_rsp
         assign m_ready[gi] = busy_w & grant_q[gi] & s_ready;
         assign m_err[gi]   = busy_w & grant_q[gi] & s_ready & s_err;
      end
   endgenerate

   assign grant = grant_q;
   assign busy  = busy_w;

endmodule

// File: tb/tb_cfs_md_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cfs_md_arbiter
//
// Directed testbench for cfs_md_arbiter with three 32-bit masters. It covers
// these scenarios:
//   - a single request
//   - round-robin contention, including pointer wrap
//   - slave back-pressure
//   - error routing
//   - asynchronous reset in the middle of a transfer
//   - abort by the granted master
// -----------------------------------------------------------------------------
module tb_cfs_md_arbiter;

   localparam int NM = 3;
   localparam int DW = 32;
   localparam int OW = 2;
   localparam int SW = 3;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [NM-1:0]      m_valid;
   logic [NM*DW-1:0]   m_data;
   logic [NM*OW-1:0]   m_offset;
   logic [NM*SW-1:0]   m_size;
   logic [NM-1:0]      m_ready;
   logic [NM-1:0]      m_err;
   logic               s_valid;
   logic [DW-1:0]      s_data;
   logic [OW-1:0]      s_offset;
   logic [SW-1:0]      s_size;
   logic               s_ready;
   logic               s_err;
   logic [NM-1:0]      grant;
   logic               busy;

   int checks_cnt   = 0;
   int failures_cnt = 0;

   cfs_md_arbiter #(
      .NUM_MASTERS (NM),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_offset (m_offset),
      .m_size   (m_size),
      .m_ready  (m_ready),
      .m_err    (m_err),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_offset (s_offset),
      .s_size   (s_size),
      .s_ready  (s_ready),
      .s_err    (s_err),
      .grant    (grant),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NM-1:0] exp_order [5];
      exp_order[0] = 3'b001;
      exp_order[1] = 3'b010;
      exp_order[2] = 3'b100;
      exp_order[3] = 3'b001;
      exp_order[4] = 3'b010;

      reset_n  = 1'b0;
      m_valid  = '0;
      m_data   = '0;
      m_offset = '0;
      m_size   = '0;
      s_ready  = 1'b0;
      s_err    = 1'b0;
      #2;
      check_val("rst_grant",   grant,   0);
      check_val("rst_busy",    busy,    0);
      check_val("rst_s_valid", s_valid, 0);
      check_val("rst_m_ready", m_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // ---------------- single request: master1 ----------------
      step();
      m_valid                = 3'b010;
      m_data[1*DW +: DW]     = 32'hA5A5_0001;
      m_offset[1*OW +: OW]   = 2'd1;
      m_size[1*SW +: SW]     = 3'd2;
      s_ready                = 1'b1;
      settle();
      check_val("single_idle_busy",    busy,    0);
      check_val("single_idle_s_valid", s_valid, 0);
      check_val("single_idle_m_ready", m_ready, 0);
      step();
      check_val("single_grant",    grant,    3'b010);
      check_val("single_busy",     busy,     1);
      check_val("single_s_valid",  s_valid,  1);
      check_val("single_s_data",   s_data,   32'hA5A5_0001);
      check_val("single_s_offset", s_offset, 1);
      check_val("single_s_size",   s_size,   2);
      check_val("single_m_ready",  m_ready,  3'b010);
      step();
      m_valid = '0;
      settle();
      check_val("single_done_grant",   grant,   0);
      check_val("single_done_busy",    busy,    0);
      check_val("single_done_m_ready", m_ready, 0);
      check_val("single_done_s_data",  s_data,  0);

      // ---------------- contention from reset ----------------
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      m_valid = 3'b111;
      s_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check_val($sformatf("rr_grant_%0d", i), grant, exp_order[i]);
         step();
         check_val($sformatf("rr_bubble_%0d", i), grant, 0);
      end
      // ptr is now 2 (after master1 completed)

      // ---------------- back-pressure + error routing ----------------
      m_valid              = 3'b011;
      s_ready              = 1'b0;
      m_data[0*DW +: DW]   = 32'h1234_5678;
      m_offset[0*OW +: OW] = 2'd3;
      m_size[0*SW +: SW]   = 3'd1;
      m_data[1*DW +: DW]   = 32'hCAFE_0002;
      for (int k = 0; k < 4; k++) begin
         step();
         check_val($sformatf("bp_grant_%0d", k),   grant,   3'b001);
         check_val($sformatf("bp_s_valid_%0d", k), s_valid, 1);
         check_val($sformatf("bp_s_data_%0d", k),  s_data,  32'h1234_5678);
         check_val($sformatf("bp_m_ready_%0d", k), m_ready, 0);
         check_val($sformatf("bp_m_err_%0d", k),   m_err,   0);
      end
      s_ready = 1'b1;
      settle();
      check_val("bp_release_m_ready", m_ready, 3'b001);
      step();
      check_val("bp_bubble_grant", grant, 0);
      step();
      check_val("bp_next_grant", grant, 3'b010);
      check_val("bp_next_data",  s_data, 32'hCAFE_0002);
      s_err = 1'b1;
      settle();
      check_val("err_m_err",   m_err,   3'b010);
      check_val("err_m_ready", m_ready, 3'b010);
      step();
      s_err = 1'b0;
      settle();
      check_val("err_after_m_err", m_err, 0);
      check_val("err_after_grant", grant, 0);
      // ptr is now 2

      // ---------------- reset mid-transfer ----------------
      m_valid = 3'b010;
      s_ready = 1'b0;
      step();
      check_val("mid_grant_before", grant, 3'b010);
      reset_n = 1'b0;
      settle();
      check_val("mid_rst_grant",   grant,   0);
      check_val("mid_rst_busy",    busy,    0);
      check_val("mid_rst_s_valid", s_valid, 0);
      m_valid = 3'b111;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check_val("mid_after_grant", grant, 3'b001);
      s_ready = 1'b1;
      step();
      check_val("mid_done_grant", grant, 0);
      // ptr is now 1

      // ---------------- abort ----------------
      s_ready = 1'b0;
      step();
      check_val("abort_grant", grant, 3'b010);
      m_valid = 3'b001;
      settle();
      check_val("abort_s_valid", s_valid, 0);
      step();
      m_valid = 3'b011;
      settle();
      check_val("abort_idle_busy",  busy,  0);
      check_val("abort_idle_grant", grant, 0);
      step();
      check_val("abort_ptr_grant", grant, 3'b001);

      m_valid = '0;
      s_ready = 1'b1;
      step();
      step();
      check_val("final_idle_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule
